// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster interface between the VGA timing generator and pixel sources
interface vga_timing_gen_if;
  logic        clk_en;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        vga_hs;
  logic        vga_vs;
  logic        vga_blank_n;
  logic        vga_sync_n;
  logic        line_start;
  logic        frame_start;
  logic [15:0] frame_count;

  modport master (
    input  clk_en,
    output hcount, vcount, vga_hs, vga_vs, vga_blank_n, vga_sync_n,
           line_start, frame_start, frame_count
  );

  modport slave (
    output clk_en,
    input  hcount, vcount, vga_hs, vga_vs, vga_blank_n, vga_sync_n,
           line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters with latency-matched sync/blank
// Optional frame counter enabled by defining VGA_FRAME_COUNTER_EN.
module vga_timing_gen #(
  parameter int H_VISIBLE     = 640,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_VISIBLE     = 480,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33,
  parameter int PIXEL_LATENCY = 1
) (
  input logic              vga_clk,
  input logic              reset,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

  // {hs, vs, blank_n} value the pipeline holds outside active video
  localparam logic [2:0] IDLE = 3'b110;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_err
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if (PIXEL_LATENCY < 0 || PIXEL_LATENCY > 4) begin : g_latency_err
    $error("vga_timing_gen: PIXEL_LATENCY must be within 0..4");
  end

  logic [9:0] hcount_q;
  logic [9:0] vcount_q;
  logic       h_last;
  logic       v_last;

  assign h_last = (hcount_q == H_LAST);
  assign v_last = (vcount_q == V_LAST);

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hcount_q <= '0;
      vcount_q <= '0;
    end else if (vga.clk_en) begin
      if (h_last) begin
        hcount_q <= '0;
        vcount_q <= v_last ? '0 : vcount_q + 10'd1;
      end else begin
        hcount_q <= hcount_q + 10'd1;
      end
    end
  end

  logic [10:0] h_ext;
  logic [10:0] v_ext;
  logic [2:0]  stage0;
  logic [2:0]  sync_out;

  assign h_ext  = {1'b0, hcount_q};
  assign v_ext  = {1'b0, vcount_q};
  assign stage0 = {!(h_ext >= HS_START && h_ext < HS_END),
                   !(v_ext >= VS_START && v_ext < VS_END),
                   (h_ext < H_VIS) && (v_ext < V_VIS)};

  // Sync/blank trail the counters by the pixel source read latency
  if (PIXEL_LATENCY == 0) begin : g_no_delay
    assign sync_out = stage0;
  end else if (PIXEL_LATENCY > 0) begin : g_delay
    logic [2:0] pipe [PIXEL_LATENCY];

    always_ff @(posedge vga_clk) begin
      if (reset) begin
        for (int i = 0; i < PIXEL_LATENCY; i++) pipe[i] <= IDLE;
      end else if (vga.clk_en) begin
        pipe[0] <= stage0;
        for (int i = 1; i < PIXEL_LATENCY; i++) pipe[i] <= pipe[i-1];
      end
    end

    assign sync_out = pipe[PIXEL_LATENCY-1];
  end else begin : g_bad_latency
    assign sync_out = IDLE;
  end

  assign vga.hcount      = hcount_q;
  assign vga.vcount      = vcount_q;
  assign vga.vga_hs      = sync_out[2];
  assign vga.vga_vs      = sync_out[1];
  assign vga.vga_blank_n = sync_out[0];
  assign vga.vga_sync_n  = 1'b0;
  assign vga.line_start  = vga.clk_en && !reset && (hcount_q == '0);
  assign vga.frame_start = vga.clk_en && !reset && (hcount_q == '0) && (vcount_q == '0);

`ifdef VGA_FRAME_COUNTER_EN
  logic [15:0] frame_count_q;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      frame_count_q <= '0;
    end else if (vga.clk_en && h_last && v_last) begin
      frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign vga.frame_count = frame_count_q;
`else
  assign vga.frame_count = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

  logic vga_clk;
  logic reset;
  logic clk_en;
  int   slots;
  bit   chk_en;
  int   n_cmp;
  int   n_bad;
  int   fs_k[$];
  int   cnt_bn_z, cnt_hs_z, cnt_ls_z, cnt_vs_s;

  vga_timing_gen_if if_d ();
  vga_timing_gen_if if_z ();
  vga_timing_gen_if if_s ();

  assign if_d.clk_en = clk_en;
  assign if_z.clk_en = clk_en;
  assign if_s.clk_en = clk_en;

  vga_timing_gen #(.PIXEL_LATENCY(1)) dut_d (.vga_clk(vga_clk), .reset(reset), .vga(if_d));
  vga_timing_gen #(.PIXEL_LATENCY(0)) dut_z (.vga_clk(vga_clk), .reset(reset), .vga(if_z));
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .PIXEL_LATENCY(2)
  ) dut_s (.vga_clk(vga_clk), .reset(reset), .vga(if_s));

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // {hs, vs, blank_n} straight from the raster rules
  function automatic logic [2:0] raster(int h, int v, int hv, int hfp, int hsy, int vv, int vfp, int vsy);
    logic hs, vs, bn;
    hs = !(h >= hv + hfp && h < hv + hfp + hsy);
    vs = !(v >= vv + vfp && v < vv + vfp + vsy);
    bn = (h < hv) && (v < vv);
    return {hs, vs, bn};
  endfunction

  task automatic check_dut(string t, int hv, int hfp, int hsy, int hbp, int vv, int vfp, int vsy, int vbp, int lat,
                           logic [9:0] hc, logic [9:0] vc, logic hs, logic vs, logic bn, logic sn,
                           logic ls, logic fs, logic [15:0] fc);
    int ht, vt, h, v, s, frames;
    logic [2:0] e;
    ht = hv + hfp + hsy + hbp;
    vt = vv + vfp + vsy + vbp;
    h  = slots % ht;
    v  = (slots / ht) % vt;
    if (slots < lat) e = 3'b110;
    else begin
      s = slots - lat;
      e = raster(s % ht, (s / ht) % vt, hv, hfp, hsy, vv, vfp, vsy);
    end
`ifdef VGA_FRAME_COUNTER_EN
    frames = (slots / (ht * vt)) % 65536;
`else
    frames = 0;
`endif
    cmp({t, ".hcount"}, 32'(hc), h);
    cmp({t, ".vcount"}, 32'(vc), v);
    cmp({t, ".vga_hs"}, 32'(hs), 32'(e[2]));
    cmp({t, ".vga_vs"}, 32'(vs), 32'(e[1]));
    cmp({t, ".vga_blank_n"}, 32'(bn), 32'(e[0]));
    cmp({t, ".vga_sync_n"}, 32'(sn), 0);
    cmp({t, ".line_start"}, 32'(ls), 32'(clk_en && !reset && h == 0));
    cmp({t, ".frame_start"}, 32'(fs), 32'(clk_en && !reset && h == 0 && v == 0));
    cmp({t, ".frame_count"}, 32'(fc), frames);
  endtask

  // Slot count since reset is the whole model state
  always @(posedge vga_clk) begin
    if (reset) slots = 0;
    else if (clk_en) slots = slots + 1;
  end

  always @(negedge vga_clk) begin
    if (chk_en) begin
      check_dut("d", 640, 16, 96, 48, 480, 10, 2, 33, 1, if_d.hcount, if_d.vcount, if_d.vga_hs,
                if_d.vga_vs, if_d.vga_blank_n, if_d.vga_sync_n, if_d.line_start, if_d.frame_start, if_d.frame_count);
      check_dut("z", 640, 16, 96, 48, 480, 10, 2, 33, 0, if_z.hcount, if_z.vcount, if_z.vga_hs,
                if_z.vga_vs, if_z.vga_blank_n, if_z.vga_sync_n, if_z.line_start, if_z.frame_start, if_z.frame_count);
      check_dut("s", 8, 2, 3, 2, 4, 1, 2, 1, 2, if_s.hcount, if_s.vcount, if_s.vga_hs,
                if_s.vga_vs, if_s.vga_blank_n, if_s.vga_sync_n, if_s.line_start, if_s.frame_start, if_s.frame_count);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    n_cmp = 0; n_bad = 0; chk_en = 1'b0; slots = 0;
    cnt_bn_z = 0; cnt_hs_z = 0; cnt_ls_z = 0; cnt_vs_s = 0;
    reset = 1'b1;
    clk_en = 1'b1;
    repeat (3) @(posedge vga_clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;

    // Free-running with clk_en held high; negedge k sees slot k
    for (int k = 0; k < 1000; k++) begin
      @(negedge vga_clk);
      if (k < 800) begin
        cnt_bn_z += int'(if_z.vga_blank_n);
        cnt_hs_z += int'(!if_z.vga_hs);
        cnt_ls_z += int'(if_z.line_start);
      end
      if (k >= 2 && k < 242) cnt_vs_s += int'(!if_s.vga_vs);
      if (if_s.frame_start === 1'b1) fs_k.push_back(k);
      case (k)
        0: begin
          cmp("lit.d.hcount0", 32'(if_d.hcount), 0);
          cmp("lit.d.vcount0", 32'(if_d.vcount), 0);
          cmp("lit.d.hs_idle", 32'(if_d.vga_hs), 1);
          cmp("lit.d.vs_idle", 32'(if_d.vga_vs), 1);
          cmp("lit.d.blank_idle", 32'(if_d.vga_blank_n), 0);
          cmp("lit.d.frame_start0", 32'(if_d.frame_start), 1);
          cmp("lit.z.blank0", 32'(if_z.vga_blank_n), 1);
          cmp("lit.s.blank0", 32'(if_s.vga_blank_n), 0);
        end
        1: begin
          cmp("lit.d.blank1", 32'(if_d.vga_blank_n), 1);
          cmp("lit.d.frame_start1", 32'(if_d.frame_start), 0);
          cmp("lit.s.blank1", 32'(if_s.vga_blank_n), 0);
        end
        2:   cmp("lit.s.blank2", 32'(if_s.vga_blank_n), 1);
        11:  cmp("lit.s.hs11", 32'(if_s.vga_hs), 1);
        12:  cmp("lit.s.hs12", 32'(if_s.vga_hs), 0);
        640: begin
          cmp("lit.z.blank640", 32'(if_z.vga_blank_n), 0);
          cmp("lit.d.blank640", 32'(if_d.vga_blank_n), 1);
        end
        641: cmp("lit.d.blank641", 32'(if_d.vga_blank_n), 0);
        656: begin
          cmp("lit.z.hs656", 32'(if_z.vga_hs), 0);
          cmp("lit.d.hs656", 32'(if_d.vga_hs), 1);
        end
        657: cmp("lit.d.hs657", 32'(if_d.vga_hs), 0);
        752: cmp("lit.z.hs752", 32'(if_z.vga_hs), 1);
        799: begin
          cmp("lit.z.hcount799", 32'(if_z.hcount), 799);
          cmp("lit.z.vcount799", 32'(if_z.vcount), 0);
        end
        800: begin
          cmp("lit.z.hcount800", 32'(if_z.hcount), 0);
          cmp("lit.z.vcount800", 32'(if_z.vcount), 1);
          cmp("lit.z.line_start800", 32'(if_z.line_start), 1);
        end
        999: begin
`ifdef VGA_FRAME_COUNTER_EN
          cmp("lit.s.frame_count", 32'(if_s.frame_count), 8);
`else
          cmp("lit.s.frame_count", 32'(if_s.frame_count), 0);
`endif
        end
        default: ;
      endcase
    end
    cmp("z.blank_slots_line", cnt_bn_z, 640);
    cmp("z.hs_low_slots_line", cnt_hs_z, 96);
    cmp("z.line_start_per_line", cnt_ls_z, 1);
    cmp("s.vs_low_slots_2frames", cnt_vs_s, 60);
    cmp("s.frame_start_period", (fs_k.size() >= 2) ? 32'(fs_k[1] - fs_k[0]) : 32'hFFFF_FFFF, 120);

    // 25 MHz slot rate from a 50 MHz clock: enable pattern 1-0-0-1
    for (int j = 0; j < 1200; j++) begin
      @(posedge vga_clk);
      #1 clk_en = (j % 4 == 0) || (j % 4 == 3);
    end

    // One-cycle mid-frame reset
    @(posedge vga_clk);
    #1 begin reset = 1'b1; clk_en = 1'b1; end
    @(negedge vga_clk);
    cmp("lit.d.line_start_in_reset", 32'(if_d.line_start), 0);
    cmp("lit.d.frame_start_in_reset", 32'(if_d.frame_start), 0);
    @(posedge vga_clk);
    #1 reset = 1'b0;
    for (int r = 0; r < 300; r++) begin
      @(negedge vga_clk);
      case (r)
        0: begin
          cmp("lit.rst.d.hcount", 32'(if_d.hcount), 0);
          cmp("lit.rst.d.vcount", 32'(if_d.vcount), 0);
          cmp("lit.rst.d.blank_idle", 32'(if_d.vga_blank_n), 0);
          cmp("lit.rst.d.hs_idle", 32'(if_d.vga_hs), 1);
          cmp("lit.rst.d.frame_start", 32'(if_d.frame_start), 1);
          cmp("lit.rst.s.blank0", 32'(if_s.vga_blank_n), 0);
        end
        1: begin
          cmp("lit.rst.s.blank1", 32'(if_s.vga_blank_n), 0);
          cmp("lit.rst.d.blank1", 32'(if_d.vga_blank_n), 1);
        end
        2: cmp("lit.rst.s.blank2", 32'(if_s.vga_blank_n), 1);
        default: ;
      endcase
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
